// File: rtl/ws2812_rx.sv
// ws2812_rx: pulse-width decoder for a WS2812-style single-wire LED line.
// Each high pulse is classified by its length as a 0 or 1 bit. Bits are
// assembled MSB-first into pixels, and a long low gap ends the frame.
// Optional daisy-chain forwarding is enabled with the macro WS2812_RX_FORWARD_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// WAIT_GAP | out of sync: wait for RESET_CYCLES consecutive low samples
// IDLE     | in sync, between frames: wait for a rising edge
// HIGH     | measuring a high pulse
// LOW      | between bits: wait for the next pulse or the frame gap
module ws2812_rx #(
    parameter int CHANNELS      = 3,
    parameter int BITPERCHANNEL = 8,
    parameter int INDEXWIDTH    = 8,
    parameter int MIN_HIGH      = 3,
    parameter int BIT_THRESH    = 15,
    parameter int MAX_HIGH      = 30,
    parameter int RESET_CYCLES  = 1250,
    localparam int PIXELWIDTH   = CHANNELS * BITPERCHANNEL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    output logic [PIXELWIDTH-1:0] pixel_o,
    output logic                  pixel_valid_o,
    output logic [INDEXWIDTH-1:0] pixel_index_o,
    output logic                  frame_done_o,
    output logic                  error_o,
    output logic                  dout_o
);

    localparam int HCW = $clog2(MAX_HIGH + 2);
    localparam int LCW = $clog2(RESET_CYCLES + 1);
    localparam int BCW = $clog2(PIXELWIDTH + 1);

    localparam logic [HCW-1:0] HIGH_SAT = HCW'(MAX_HIGH + 1);
    localparam logic [HCW-1:0] MIN_H    = HCW'(MIN_HIGH);
    localparam logic [HCW-1:0] THRESH_H = HCW'(BIT_THRESH);
    localparam logic [LCW-1:0] LOW_SAT  = LCW'(RESET_CYCLES);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(PIXELWIDTH - 1);

`ifdef WS2812_RX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

    state_t                  state_q, state_d;
    logic                    din_meta, din_s;
    logic [HCW-1:0]          high_cnt_q, high_cnt_d;
    logic [LCW-1:0]          low_cnt_q, low_cnt_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PIXELWIDTH-1:0]   shift_q, shift_d;
    logic [INDEXWIDTH-1:0]   index_q, index_d;
    logic                    fwd_q, fwd_d;
    logic [PIXELWIDTH-1:0]   pixel_q, pixel_d;
    logic [INDEXWIDTH-1:0]   pidx_q, pidx_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    // Two-flop synchroniser for the asynchronous line.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_GAP;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            index_q    <= '0;
            fwd_q      <= 1'b0;
            pixel_q    <= '0;
            pidx_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            index_q    <= index_d;
            fwd_q      <= fwd_d;
            pixel_q    <= pixel_d;
            pidx_q     <= pidx_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state, pulse classification and strobe generation.
    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        index_d    = index_q;
        fwd_d      = fwd_q;
        pixel_d    = pixel_q;
        pidx_d     = pidx_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            WAIT_GAP: begin
                if (din_s) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_cnt_q + LCW'(1);
                    if (low_cnt_d == LOW_SAT) begin
                        state_d   = IDLE;
                        low_cnt_d = '0;
                    end
                end
            end
            IDLE: begin
                if (din_s) begin
                    state_d    = HIGH;
                    high_cnt_d = HCW'(1);
                end
            end
            HIGH: begin
                if (din_s) begin
                    if (high_cnt_q != HIGH_SAT)
                        high_cnt_d = high_cnt_q + HCW'(1);
                    // While forwarding, later pulses are not error-checked.
                    if (high_cnt_d == HIGH_SAT && !fwd_q) begin
                        err_d     = 1'b1;
                        state_d   = WAIT_GAP;
                        low_cnt_d = '0;
                        bit_cnt_d = '0;
                        index_d   = '0;
                    end
                end else if (fwd_q) begin
                    state_d   = LOW;
                    low_cnt_d = LCW'(1);
                end else if (high_cnt_q < MIN_H) begin
                    // The falling sample is already the first low of the gap.
                    err_d     = 1'b1;
                    state_d   = WAIT_GAP;
                    low_cnt_d = LCW'(1);
                    bit_cnt_d = '0;
                    index_d   = '0;
                end else begin
                    state_d   = LOW;
                    low_cnt_d = LCW'(1);
                    shift_d   = {shift_q[PIXELWIDTH-2:0], (high_cnt_q >= THRESH_H)};
                    if (bit_cnt_q == BIT_LAST) begin
                        pixel_d   = shift_d;
                        pidx_d    = index_q;
                        index_d   = index_q + INDEXWIDTH'(1);
                        bit_cnt_d = '0;
                        valid_d   = 1'b1;
                        fwd_d     = FWD_EN;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            LOW: begin
                if (din_s) begin
                    state_d    = HIGH;
                    high_cnt_d = HCW'(1);
                end else begin
                    if (low_cnt_q != LOW_SAT)
                        low_cnt_d = low_cnt_q + LCW'(1);
                    if (low_cnt_d == LOW_SAT) begin
                        done_d    = 1'b1;
                        err_d     = (bit_cnt_q != '0);
                        state_d   = IDLE;
                        index_d   = '0;
                        bit_cnt_d = '0;
                        fwd_d     = 1'b0;
                    end
                end
            end
            default: state_d = WAIT_GAP;
        endcase
    end

    assign pixel_o       = pixel_q;
    assign pixel_index_o = pidx_q;
    assign pixel_valid_o = valid_q;
    assign frame_done_o  = done_q;
    assign error_o       = err_q;

`ifdef WS2812_RX_FORWARD_EN
    assign dout_o = fwd_q & din_s;
`else
    assign dout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized pulse-level stimulus for ws2812_rx checked against
// a pulse/gap-level frame model. Honours WS2812_RX_FORWARD_EN when defined.
module tb_ws2812_rx;
    localparam int PW   = 24;
    localparam int RC   = 1250;
    localparam int MINH = 3;
    localparam int THR  = 15;
    localparam int MAXH = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] pixel_o;
    logic        pixel_valid_o;
    logic [7:0]  pixel_index_o;
    logic        frame_done_o;
    logic        error_o;
    logic        dout_o;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .pixel_o       (pixel_o),
        .pixel_valid_o (pixel_valid_o),
        .pixel_index_o (pixel_index_o),
        .frame_done_o  (frame_done_o),
        .error_o       (error_o),
        .dout_o        (dout_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame rules applied per whole pulse / low period.
    bit          m_sync, m_active, m_fwd;
    int          m_nbits, m_idx;
    logic [23:0] m_acc;
    logic [31:0] exp_q[$];
    int          exp_done, exp_err, exp_both;

    logic [31:0] got_q[$];
    int          got_done, got_err, got_both, bad_overlap, dout_stray, fwd_mism, fwd_high;
    bit          fwd_win;
    logic        d1, d2;

    task automatic m_reset();
        m_sync = 0; m_active = 0; m_fwd = 0; m_nbits = 0; m_idx = 0; m_acc = '0;
    endtask

    task automatic m_pulse(input int h);
        if (!m_sync) return;
        m_active = 1;
        if (m_fwd) return;
        if (h < MINH || h > MAXH) begin
            exp_err++;
            m_sync = 0; m_active = 0; m_nbits = 0; m_idx = 0;
            return;
        end
        m_acc = {m_acc[22:0], (h >= THR) ? 1'b1 : 1'b0};
        m_nbits++;
        if (m_nbits == PW) begin
            exp_q.push_back({m_idx[7:0], m_acc});
            m_idx = (m_idx + 1) % 256;
            m_nbits = 0;
`ifdef WS2812_RX_FORWARD_EN
            m_fwd = 1;
`endif
        end
    endtask

    task automatic m_low(input int n);
        if (n < RC) return;
        if (m_sync && m_active) begin
            exp_done++;
            if (m_nbits != 0) begin
                exp_err++;
                exp_both++;
            end
        end
        m_sync = 1; m_active = 0; m_nbits = 0; m_idx = 0; m_fwd = 0;
    endtask

    // Spec-level delay of the line by two clocks, used for the forwarding check.
    always @(posedge clk) begin
        d1 <= din;
        d2 <= d1;
    end

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (pixel_valid_o) got_q.push_back({pixel_index_o, pixel_o});
        if (frame_done_o) got_done++;
        if (error_o) got_err++;
        if (frame_done_o && error_o) got_both++;
        if (pixel_valid_o && (frame_done_o || error_o)) bad_overlap++;
`ifdef WS2812_RX_FORWARD_EN
        if (pixel_valid_o) fwd_win = 1;
        if (frame_done_o || reset) fwd_win = 0;
        if (fwd_win) begin
            if (dout_o !== d2) fwd_mism++;
            if (dout_o) fwd_high++;
        end else if (dout_o !== 1'b0) begin
            dout_stray++;
        end
`else
        if (dout_o !== 1'b0) dout_stray++;
`endif
    end

    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        drive(1'b1, h); m_pulse(h);
        drive(1'b0, l); m_low(l);
    endtask

    task automatic gap();
        drive(1'b0, 1300); m_low(1300);
    endtask

    task automatic send_pix(input logic [23:0] p, input bit rnd);
        for (int i = 23; i >= 0; i--) begin
            int h, l;
            if (p[i]) h = rnd ? $urandom_range(MAXH, THR) : 20;
            else      h = rnd ? $urandom_range(THR - 1, MINH) : 10;
            l = rnd ? $urandom_range(40, 2) : 31 - h;
            pulse(h, l);
        end
    endtask

    task automatic settle_check(input string tag);
        int n;
        logic [31:0] last;
        repeat (8) @(negedge clk);
        chk({tag, "_npix"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_pix"}, got_q[i], exp_q[i]);
        if (exp_q.size() > 0) begin
            last = exp_q[exp_q.size() - 1];
            chk({tag, "_hold"}, {pixel_index_o, pixel_o}, last);
        end
        chk({tag, "_done"}, got_done, exp_done);
        chk({tag, "_err"}, got_err, exp_err);
        chk({tag, "_both"}, got_both, exp_both);
        got_q.delete(); exp_q.delete();
        got_done = 0; got_err = 0; got_both = 0;
        exp_done = 0; exp_err = 0; exp_both = 0;
    endtask

    initial begin
        int npix;
        fwd_win = 0;
        din = 1'b0;
        reset = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_pixel", pixel_o, 0);
        chk("rst_index", pixel_index_o, 0);
        chk("rst_strobes", {pixel_valid_o, frame_done_o, error_o, dout_o}, 0);
        reset = 1'b0;

        // No gap after reset: pixel ignored, then a gap syncs.
        send_pix(24'h123456, 0);
        gap();
        send_pix(24'hFF0080, 0);
        gap();
        settle_check("first");

        // Three pixels, then a second frame restarting at index 0.
        gap();
        send_pix(24'h010203, 0);
        send_pix(24'hA5A5A5, 0);
        send_pix(24'h000000, 0);
        gap();
        send_pix(24'hC3C3C3, 1);
        gap();
        settle_check("three");

        // Partial pixel ended by a gap.
        for (int i = 0; i < 12; i++) pulse((i % 2) ? 20 : 10, 11);
        gap();
        settle_check("partial");

        // Glitch and stuck-high pulses force a resync.
        for (int i = 0; i < 5; i++) pulse(20, 11);
        pulse(2, 20);
        send_pix(24'h777777, 0);
        gap();
        send_pix(24'h0F0F0F, 0);
        gap();
        settle_check("glitch");
        for (int i = 0; i < 7; i++) pulse(10, 21);
        pulse(40, 20);
        send_pix(24'h888888, 1);
        gap();
        send_pix(24'hF0F0F0, 1);
        gap();
        settle_check("stuck");

        // Random frames with random pulse timing, one carrying a glitch.
        for (int f = 0; f < 4; f++) begin
            npix = $urandom_range(3, 1);
            for (int p = 0; p < npix; p++) send_pix(24'($urandom()), 1);
            if (f == 3) begin
                pulse($urandom_range(2, 1), 10);
                send_pix(24'($urandom()), 1);
            end
            gap();
            settle_check("rand");
        end

        // Reset in the middle of a pixel.
        send_pix(24'h5A5A5A, 0);
        gap();
        settle_check("prerst");
        for (int i = 0; i < 10; i++) pulse(20, 11);
        drive(1'b1, 5);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_pixel", pixel_o, 0);
        chk("midrst_index", pixel_index_o, 0);
        chk("midrst_strobes", {pixel_valid_o, frame_done_o, error_o, dout_o}, 0);
        reset = 1'b0;
        din = 1'b0;
        m_reset();
        got_q.delete(); got_done = 0; got_err = 0; got_both = 0;
        send_pix(24'h111111, 0);
        gap();
        send_pix(24'h3C00FF, 0);
        gap();
        settle_check("postrst");

`ifdef WS2812_RX_FORWARD_EN
        fwd_high = 0; fwd_mism = 0;
        send_pix(24'h123456, 1);
        send_pix(24'hABCDEF, 1);
        gap();
        settle_check("fwd");
        chk("fwd_mism", fwd_mism, 0);
        chk("fwd_seen", (fwd_high > 0) ? 1 : 0, 1);
`endif

        chk("overlap", bad_overlap, 0);
        chk("dout_stray", dout_stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
